uart_to_bram: RTL and testbench
===============================

Name: uart_to_bram

Overview:
- UART receiver that deserialises 8N1 bytes from the host and writes them sequentially into a single-port BRAM from address 0.
- Inverse path of the BRAM-to-UART transmitter: loads input samples or coefficients into block RAM before convolution runs.
- Raises a latched load_done after NUM_BYTES good bytes, so downstream logic knows the memory image is complete.

Parameters:
CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4
NUM_BYTES, 1024, bytes to store before load_done asserts; range 1..2^32-1
ADDR_W, 32, BRAM address width

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
rx_serial  input  1  UART RX pin; asynchronous, idle high
ena  output  1  BRAM enable
wea  output  1  BRAM write enable
addr  output  ADDR_W  BRAM write address
din  output  8  signed BRAM write data
rx_valid  output  1  one-cycle pulse per good byte, coincident with the write
load_done  output  1  sticky: NUM_BYTES bytes written
frame_err  output  1  sticky: at least one stop bit sampled low
debug_state  output  3  current FSM state encoding, for LEDs

Behaviour:
- Reset (reset=0, async): state IDLE; ena=wea=rx_valid=load_done=frame_err=0; addr=0; din=0; bit counter and baud counter cleared; synchroniser flops set to 1.
- rx_serial passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s, so there is 2 cycles of input latency.
- States: IDLE=0, START=1, DATA=2, STOP=3, WRITE=4, BREAK=5, DONE=6.
- IDLE: if rx_s==0, go to START with baud counter=0.
- START: count to (CLKS_PER_BIT-1)/2.
  - If rx_s is still 0, go to DATA with counter=0 and bit index=0.
  - Otherwise treat as a glitch and return to IDLE. Nothing is written.
- DATA: count to CLKS_PER_BIT-1, then sample rx_s into shift[bit_idx], LSB first. After bit 7, go to STOP.
- STOP: count to CLKS_PER_BIT-1, then sample.
  - rx_s==1: go to WRITE.
  - rx_s==0: set frame_err=1, discard the byte, go to BREAK.
- WRITE: exactly one cycle with ena=wea=1, din=shift, addr=current address, rx_valid=1.
  - Next cycle: addr increments by 1.
  - If this write was byte NUM_BYTES, set load_done=1 and go to DONE. Otherwise go to IDLE.
- BREAK: wait until rx_s==1, then go to IDLE. Handles a line held low.
- DONE: terminal. ena=wea=0, addr holds NUM_BYTES, and further UART traffic is ignored. Only reset leaves DONE.
- ena and wea are 0 in every state except WRITE, so an arbiter may OR ena with other BRAM masters.
- din holds its last written value outside WRITE.
- Reset during any state aborts immediately. A partial byte is lost and no write occurs.
- Address wrap: addr is ADDR_W bits wide and never exceeds NUM_BYTES, so no wrap occurs.
- Back-to-back frames: a start bit arriving while in WRITE or one cycle after is detected. The WRITE state ends mid-stop-bit, so the next falling edge is always seen from IDLE.
- Baud tolerance: sampling at mid-bit tolerates about ±4% clock mismatch over 10 bits.

Test Plan:
1. CLKS_PER_BIT=8, NUM_BYTES=4; send 0x3C, 0xA5, 0x00, 0xFF.
   -> four single-cycle writes at addr 0,1,2,3 with din 0x3C, 0xA5, 0x00, 0xFF; load_done rises the cycle after the 4th write; frame_err=0.
2. After test 1, send 0x55.
   -> no ena pulse; addr stays 4; state stays DONE.
3. Pulse rx low for 2 cycles (shorter than half a bit), then send 0x81.
   -> no write for the glitch; 0x81 written at addr 0.
4. Send a frame 0x5A with stop bit 0, hold the line low for 40 cycles, then send 0x12.
   -> frame_err=1; no write for 0x5A; FSM waits in BREAK until the line goes high; 0x12 written at addr 0.
5. Assert reset=0 mid-DATA of the 2nd byte (1st byte 0x11 already written), release, then send 0x22.
   -> outputs clear asynchronously; 0x22 written at addr 0; load_done=0.
6. Send 4 back-to-back frames with zero idle gap between stop and start bits.
   -> all four bytes are written; each rx_valid pulse is spaced 10×CLKS_PER_BIT cycles apart.

Source files
------------

// File: rtl/uart_to_bram.sv
// -----------------------------------------------------------------------------
// uart_to_bram
//
// This block receives 8N1 UART bytes from the host. It writes each good byte
// in turn into a single-port BRAM, starting at address 0. Its job is to fill
// block RAM with input samples or coefficients before convolution starts.
// After NUM_BYTES good bytes it raises a sticky load_done. It then stays in
// DONE and ignores all further line traffic until reset.
//
// Ports
//   clk          system clock; all logic runs on the rising edge
//   reset        asynchronous active-low reset (0 = in reset)
//   rx_serial    UART RX pin; asynchronous to clk, idles high
//   ena, wea     BRAM enable / write enable; high only in the WRITE cycle
//   addr         BRAM write address; increments after every write
//   din          BRAM write data; holds the last written byte
//   rx_valid     one-cycle pulse per good byte, in the same cycle as the write
//   load_done    sticky; set once NUM_BYTES bytes have been written
//   frame_err    sticky; set when any stop bit is sampled low
//   debug_state  current FSM state encoding, intended for LEDs
// -----------------------------------------------------------------------------
module uart_to_bram #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned NUM_BYTES    = 1024,
  parameter int unsigned ADDR_W       = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_serial,
  output logic              ena,
  output logic              wea,
  output logic [ADDR_W-1:0] addr,
  output logic signed [7:0] din,
  output logic              rx_valid,
  output logic              load_done,
  output logic              frame_err,
  output logic [2:0]        debug_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    WRITE = 3'd4,
    BREAK = 3'd5,
    DONE  = 3'd6
  } state_t;

  localparam int unsigned     CNT_W     = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] HALF_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CNT_W-1:0] FULL_BIT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_meta;
  logic             rx_s;

  // rx_serial is not related to clk, so it passes through two flops first.
  // Both flops reset to 1, the idle line level. This way a reset release
  // cannot look like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the values from before the edge. With blocking assignments
      // rx_s would get rx_serial in the same cycle and one stage would vanish.
      rx_meta <= rx_serial;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      ena       <= 1'b0;
      wea       <= 1'b0;
      rx_valid  <= 1'b0;
      addr      <= '0;
      din       <= '0;
      load_done <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // NOTE: these strobes clear by default on every cycle. Only the
      // STOP->WRITE transition raises them, so each one lasts exactly one cycle.
      ena      <= 1'b0;
      wea      <= 1'b0;
      rx_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state    <= START;
            baud_cnt <= '0;
          end
        end

        // Recheck the line at the middle of the start bit. A low pulse that
        // is shorter than half a bit counts as noise and is dropped.
        START: begin
          if (baud_cnt == HALF_BIT) begin
            baud_cnt <= '0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= '0;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // From here on every sample falls one full bit after the previous
        // one, which lands each sample at mid-bit. Bits arrive LSB first.
        DATA: begin
          if (baud_cnt == FULL_BIT) begin
            baud_cnt       <= '0;
            shift[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_cnt == FULL_BIT) begin
            baud_cnt <= '0;
            if (rx_s) begin
              state    <= WRITE;
              ena      <= 1'b1;
              wea      <= 1'b1;
              rx_valid <= 1'b1;
              din      <= $signed(shift);
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        // This state lasts one cycle while the BRAM port is strobed. It ends
        // in the middle of the stop bit, so the next start edge is always
        // seen from IDLE.
        WRITE: begin
          addr <= addr + 1'b1;
          if (addr == LAST_ADDR) begin
            load_done <= 1'b1;
            state     <= DONE;
          end else begin
            state <= IDLE;
          end
        end

        // The line is held low (a break or a bad frame). Wait here until it
        // returns to idle, so the low level is not taken as a new start bit.
        BREAK: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end

        DONE: begin
          state <= DONE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign debug_state = state;

endmodule

// File: tb/tb_uart_to_bram.sv
// -----------------------------------------------------------------------------
// tb_uart_to_bram
//
// This bench drives uart_to_bram with CLKS_PER_BIT=8 and NUM_BYTES=4. Each
// test task serialises UART frames and pushes the expected BRAM writes
// (address, data) into a queue. A monitor at the falling edge pops one entry
// for every write the DUT performs and compares it.
// -----------------------------------------------------------------------------
module tb_uart_to_bram;

  localparam int unsigned C      = 8;
  localparam int unsigned NBYTES = 4;
  localparam int unsigned AW     = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } exp_t;

  logic              clk;
  logic              reset;
  logic              rx_serial;
  logic              ena;
  logic              wea;
  logic [AW-1:0]     addr;
  logic signed [7:0] din;
  logic              rx_valid;
  logic              load_done;
  logic              frame_err;
  logic [2:0]        debug_state;

  int   tests  = 0;
  int   failed = 0;
  int   cycle  = 0;
  exp_t exp_q[$];
  int   valid_cycles[$];

  uart_to_bram #(
    .CLKS_PER_BIT(C),
    .NUM_BYTES   (NBYTES),
    .ADDR_W      (AW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_serial  (rx_serial),
    .ena        (ena),
    .wea        (wea),
    .addr       (addr),
    .din        (din),
    .rx_valid   (rx_valid),
    .load_done  (load_done),
    .frame_err  (frame_err),
    .debug_state(debug_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  // Scoreboard monitor: every BRAM write must match the oldest expected entry.
  always @(negedge clk) begin
    if (ena) begin
      exp_t e;
      valid_cycles.push_back(cycle);
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL unexpected_write: addr=%0d din=%h, required no write", addr, din);
      end else begin
        e = exp_q.pop_front();
        if ({wea, rx_valid, load_done, addr, din} !== {1'b1, 1'b1, 1'b0, e.addr, e.data}) begin
          failed++;
          $display("FAIL write: wea=%b rx_valid=%b load_done=%b addr=%0d din=%h, required 1 1 0 %0d %h",
                   wea, rx_valid, load_done, addr, din, e.addr, e.data);
        end
      end
    end else if (wea || rx_valid) begin
      tests++;
      failed++;
      $display("FAIL strobe_without_ena: wea=%b rx_valid=%b, required 0 0", wea, rx_valid);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic drive_bit(input logic b);
    rx_serial = b;
    repeat (C) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rx_serial = 1'b1;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic expect_write(input logic [AW-1:0] a, input logic [7:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic check_drained(input string name);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL %s_missing_writes: %0d pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_status(input string name, input logic [AW-1:0] a, input logic ld,
                              input logic fe, input logic [2:0] st);
    tests++;
    if ({addr, load_done, frame_err, debug_state} !== {a, ld, fe, st}) begin
      failed++;
      $display("FAIL %s: addr=%0d load_done=%b frame_err=%b state=%0d, required %0d %b %b %0d",
               name, addr, load_done, frame_err, debug_state, a, ld, fe, st);
    end
  endtask

  task automatic test_reset();
    rx_serial = 1'b1;
    reset = 1'b0;
    #1;
    tests++;
    if ({ena, wea, rx_valid, load_done, frame_err, addr, din, debug_state} !== '0) begin
      failed++;
      $display("FAIL reset_outputs: ena=%b wea=%b rv=%b ld=%b fe=%b addr=%0d din=%h st=%0d, required all 0",
               ena, wea, rx_valid, load_done, frame_err, addr, din, debug_state);
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check_status("reset_idle", '0, 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_basic_load();
    logic [7:0] bytes[4];
    bytes = '{8'h3C, 8'hA5, 8'h00, 8'hFF};
    for (int i = 0; i < 4; i++) begin
      expect_write(AW'(i), bytes[i]);
      send_byte(bytes[i], 1'b1);
      drive_bit(1'b1);
    end
    check_drained("basic_load");
    check_status("basic_load_done", AW'(4), 1'b1, 1'b0, 3'd6);
  endtask

  task automatic test_done_ignores();
    send_byte(8'h55, 1'b1);
    repeat (20) @(negedge clk);
    check_status("done_ignores", AW'(4), 1'b1, 1'b0, 3'd6);
  endtask

  task automatic test_glitch();
    apply_reset();
    rx_serial = 1'b0;
    repeat (2) @(negedge clk);
    rx_serial = 1'b1;
    repeat (12) @(negedge clk);
    check_status("glitch_back_idle", '0, 1'b0, 1'b0, 3'd0);
    expect_write('0, 8'h81);
    send_byte(8'h81, 1'b1);
    drive_bit(1'b1);
    check_drained("glitch");
    check_status("glitch_after", AW'(1), 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_frame_error();
    apply_reset();
    send_byte(8'h5A, 1'b0);
    rx_serial = 1'b0;
    repeat (40) @(negedge clk);
    check_status("frame_err_break", '0, 1'b0, 1'b1, 3'd5);
    rx_serial = 1'b1;
    repeat (16) @(negedge clk);
    check_status("frame_err_idle", '0, 1'b0, 1'b1, 3'd0);
    expect_write('0, 8'h12);
    send_byte(8'h12, 1'b1);
    drive_bit(1'b1);
    check_drained("frame_err");
    check_status("frame_err_after", AW'(1), 1'b0, 1'b1, 3'd0);
  endtask

  task automatic test_reset_mid_byte();
    logic [7:0] d;
    apply_reset();
    expect_write('0, 8'h11);
    send_byte(8'h11, 1'b1);
    drive_bit(1'b1);
    check_drained("mid_reset_first");
    d = 8'h33;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(d[i]);
    check_status("mid_reset_in_data", AW'(1), 1'b0, 1'b0, 3'd2);
    reset = 1'b0;
    #1;
    tests++;
    if ({ena, wea, rx_valid, addr, din, debug_state} !== '0) begin
      failed++;
      $display("FAIL mid_reset_async: ena=%b wea=%b rv=%b addr=%0d din=%h st=%0d, required all 0",
               ena, wea, rx_valid, addr, din, debug_state);
    end
    @(negedge clk);
    rx_serial = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    expect_write('0, 8'h22);
    send_byte(8'h22, 1'b1);
    drive_bit(1'b1);
    check_drained("mid_reset");
    check_status("mid_reset_after", AW'(1), 1'b0, 1'b0, 3'd0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] bytes[4];
    bytes = '{8'hC3, 8'h7E, 8'h01, 8'h80};
    apply_reset();
    valid_cycles.delete();
    for (int i = 0; i < 4; i++) begin
      expect_write(AW'(i), bytes[i]);
      send_byte(bytes[i], 1'b1);
    end
    drive_bit(1'b1);
    check_drained("b2b");
    tests++;
    if (valid_cycles.size() != 4) begin
      failed++;
      $display("FAIL b2b_count: %0d pulses, required 4", valid_cycles.size());
    end else begin
      for (int i = 1; i < 4; i++) begin
        tests++;
        if (valid_cycles[i] - valid_cycles[i-1] != int'(10 * C)) begin
          failed++;
          $display("FAIL b2b_spacing%0d: %0d cycles, required %0d",
                   i, valid_cycles[i] - valid_cycles[i-1], 10 * C);
        end
      end
    end
    check_status("b2b_done", AW'(4), 1'b1, 1'b0, 3'd6);
  endtask

  initial begin
    reset     = 1'b1;
    rx_serial = 1'b1;
    #2;
    test_reset();
    test_basic_load();
    test_done_ignores();
    test_glitch();
    test_frame_error();
    test_reset_mid_byte();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
